// File: rtl/bus_pkg.sv
// Shared types and constants for the data-RAM bus and its arbiter.
package bus_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;

    // store_size encodings carried unchanged from master to RAM
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_M0 = 2'd1,
        ACC_M1 = 2'd2
    } arb_state_e;

    // One bus access as presented by a master and held in the grant latch
    typedef struct packed {
        logic                  we;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
        logic [1:0]            size;
    } bus_req_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin selector.
// On contention the requester that was NOT granted last wins.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_gnt_i,
    output logic       gnt_valid_o,
    output logic       gnt_idx_o
);

    // Pick a winner from the current requests and the previous grant
    always_comb begin
        gnt_valid_o = |req_i;
        gnt_idx_o   = (&req_i) ? ~last_gnt_i : req_i[1];
    end

endmodule

// File: rtl/bus_arbiter_2m.sv
// Two-master round-robin arbiter for the single data-RAM bus.
// Master 0 is the CPU data port, master 1 a DMA/debug loader.
// Each grant gives one ACC cycle with a one-cycle ack; back to IDLE after.
// Optional: define ARB_PERF_CNT_EN for saturating grant/conflict counters.
module bus_arbiter_2m
    import bus_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [1:0]        m0_size,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [1:0]        m1_size,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [1:0]        bus_size,
`ifdef ARB_PERF_CNT_EN
    output logic [CNT_W-1:0]  m0_gnt_cnt,
    output logic [CNT_W-1:0]  m1_gnt_cnt,
    output logic [CNT_W-1:0]  conflict_cnt,
`endif
    input  logic [DATA_W-1:0] bus_rdata
);

    arb_state_e state_q;
    logic       last_gnt_q;
    bus_req_t   lat_q;
    logic [1:0] ack_q;

    logic [1:0] req_vec;
    logic       gnt_valid;
    logic       gnt_idx;
    bus_req_t   sel_d;

    assign req_vec = {m1_req, m0_req};

    rr_pick2 u_pick (
        .req_i       (req_vec),
        .last_gnt_i  (last_gnt_q),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    // Fields of the master that would be granted this cycle
    always_comb begin
        if (gnt_idx) begin
            sel_d = '{we: m1_we, addr: m1_addr, wdata: m1_wdata, size: m1_size};
        end else begin
            sel_d = '{we: m0_we, addr: m0_addr, wdata: m0_wdata, size: m0_size};
        end
    end

    // Arbiter FSM: grant in IDLE, perform the access for exactly one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            lat_q      <= '0;
            ack_q      <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        state_q    <= gnt_idx ? ACC_M1 : ACC_M0;
                        last_gnt_q <= gnt_idx;
                        lat_q      <= sel_d;
                        ack_q      <= gnt_idx ? 2'b10 : 2'b01;
                    end
                end
                default: begin
                    // Any request still high here is ignored; it is re-seen in IDLE
                    state_q <= IDLE;
                    ack_q   <= 2'b00;
                end
            endcase
        end
    end

    // Bus is driven from the latch; the write strobe only exists in ACC cycles,
    // while address/data/size keep their last latched value between accesses.
    assign bus_we    = lat_q.we & (|ack_q);
    assign bus_addr  = lat_q.addr;
    assign bus_wdata = lat_q.wdata;
    assign bus_size  = lat_q.size;
    assign m0_ack    = ack_q[0];
    assign m1_ack    = ack_q[1];
    // RAM read is combinational from bus_addr, so load data is steered same-cycle
    assign m0_rdata  = ack_q[0] ? bus_rdata : '0;
    assign m1_rdata  = ack_q[1] ? bus_rdata : '0;

`ifdef ARB_PERF_CNT_EN
    logic [CNT_W-1:0] m0_cnt_q, m1_cnt_q, conf_cnt_q;
    logic             in_idle;

    assign in_idle = (state_q == IDLE);

    // Saturating grant and contention counters
    always_ff @(posedge clk) begin
        if (reset) begin
            m0_cnt_q   <= '0;
            m1_cnt_q   <= '0;
            conf_cnt_q <= '0;
        end else begin
            if (in_idle && gnt_valid && !gnt_idx && !(&m0_cnt_q)) begin
                m0_cnt_q <= m0_cnt_q + 1'b1;
            end
            if (in_idle && gnt_valid && gnt_idx && !(&m1_cnt_q)) begin
                m1_cnt_q <= m1_cnt_q + 1'b1;
            end
            if (in_idle && (&req_vec) && !(&conf_cnt_q)) begin
                conf_cnt_q <= conf_cnt_q + 1'b1;
            end
        end
    end

    assign m0_gnt_cnt   = m0_cnt_q;
    assign m1_gnt_cnt   = m1_cnt_q;
    assign conflict_cnt = conf_cnt_q;
`else
    // Counter width only matters when the counters are built
    if (CNT_W > 0) begin : g_no_perf
    end
`endif

endmodule
